// File: rtl/poly_addsub_seq.sv
// poly_addsub_seq: streams two N-coefficient polynomials (12-bit, mod Q) out of
// a dual-read source RAM pair, adds or subtracts them coefficient-wise and
// writes the results to a result RAM. It uses a fixed two-stage pipeline:
// a synchronous RAM read (1-cycle latency), then a registered result write.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   start, sub        request pulse (sampled in IDLE) and mode (0 add, 1 A-B)
//   busy, done        op in progress / one-cycle completion pulse
//   rd_en, rd_addr    shared read strobe/address for the A and B RAMs
//   a_data, b_data    source coefficients, valid the cycle after rd_en
//   wr_en, wr_addr,
//   wr_data           result RAM write port
module poly_addsub_seq #(
  parameter int N      = 256,
  parameter int ADDR_W = 8,
  parameter int Q      = 3329
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       a_data,
  input  logic [11:0]       b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data
);

  localparam int                STAGES = 2;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N - 1);
  localparam logic [12:0]       Q13    = 13'(Q);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_nx;
  logic                mode, mode_nx;
  logic                rd_en_nx;
  logic [ADDR_W-1:0]   rd_addr_nx;
  logic                done_nx;

  // vld_pipe[1] tracks read data arriving from the RAM, vld_pipe[2] is the
  // registered write strobe.
  logic [STAGES:1]     vld_pipe;
  logic [ADDR_W-1:0]   addr_d1;
  logic [12:0]         sum, diff, res;

  assign busy  = (state != IDLE);
  assign wr_en = vld_pipe[2];

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      mode    <= mode_nx;
      rd_en   <= rd_en_nx;
      rd_addr <= rd_addr_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    mode_nx    = mode;
    rd_en_nx   = rd_en;
    rd_addr_nx = rd_addr;
    done_nx    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx   = RUN;
        mode_nx    = sub;
        rd_en_nx   = 1'b1;
        rd_addr_nx = '0;
      end
      RUN: begin
        // rd_addr doubles as the read counter; it parks at LAST in DRAIN.
        if (rd_addr == LAST) begin
          rd_en_nx = 1'b0;
          state_nx = DRAIN;
        end else begin
          rd_addr_nx = rd_addr + 1'b1;
        end
      end
      DRAIN: begin
        // Last write is on the output now; finish on this edge so done
        // lands in the following cycle.
        if (wr_en && wr_addr == LAST) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- modular add/sub ----------------
  always_comb begin
    sum  = {1'b0, a_data} + {1'b0, b_data};
    diff = {1'b0, a_data} - {1'b0, b_data};
    if (!mode) res = (sum >= Q13) ? sum - Q13 : sum;
    else       res = (a_data >= b_data) ? diff : diff + Q13;
  end

  // ---------------- pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      addr_d1  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_en};
      addr_d1  <= rd_addr;
      if (vld_pipe[1]) begin
        wr_addr <= addr_d1;
        wr_data <= res[11:0];
      end
    end
  end

endmodule
